// File: rtl/mod_alu_pipe_pkg.sv
// Shared definitions for the modular ALU pipeline: op encodings, Barrett
// constant helper and the fixed pipeline latency.
package mod_alu_pipe_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  localparam int unsigned LATENCY = 4;

  // M = floor(2^(2*data_width) / q), evaluated at elaboration time.
  function automatic logic [63:0] barrett_m(input int unsigned q, input int unsigned data_width);
    logic [127:0] num;
    num = 128'd1 << (2 * data_width);
    return 64'(num / 128'(q));
  endfunction

endpackage

// File: rtl/dff_en.sv
// Stage register with synchronous active-high reset and load enable.
module dff_en #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mod_alu_pipe.sv
// Four-stage modular ALU (MUL via Barrett, ADD, SUB, PASS) with a global
// valid/ready stall; op and tag ride along with each sample.
module mod_alu_pipe
  import mod_alu_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned Q          = 3329,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_c,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned XW = 3 * DATA_WIDTH + 1;
  localparam int unsigned RW = DATA_WIDTH + 2;
  localparam int unsigned TW = DATA_WIDTH + 1;
  localparam logic [63:0]   M_FULL = barrett_m(Q, DATA_WIDTH);
  localparam logic [TW-1:0] M      = M_FULL[TW-1:0];
  localparam logic [RW-1:0] Q_R    = RW'(Q);

  function automatic logic [DATA_WIDTH-1:0] fold_barrett(input logic [RW-1:0] r);
    logic [RW-1:0] x;
    x = r;
    if (x >= Q_R) x = x - Q_R;
    if (x >= Q_R) x = x - Q_R;
    return x[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fold_add(input logic [RW-1:0] s);
    logic [RW-1:0] x;
    x = s;
    if (x >= Q_R) x = x - Q_R;
    return x[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fold_sub(input logic signed [RW-1:0] d);
    logic signed [RW-1:0] x;
    x = d;
    if (x < 0) x = x + $signed(Q_R);
    return x[DATA_WIDTH-1:0];
  endfunction

  logic                        stall;
  logic                        en;
  logic signed [DATA_WIDTH:0]  diff_p0;
  logic [PW-1:0]               raw_p0;
  logic                        vld_p1, vld_p2, vld_p3, vld_p4;
  logic [1:0]                  op_p1, op_p2, op_p3;
  logic [TAG_WIDTH-1:0]        tag_p1, tag_p2, tag_p3, tag_p4;
  logic [PW-1:0]               raw_p1;
  logic [TW-1:0]               t_p1, t_p2;
  logic [RW-1:0]               raw_p2;
  logic [RW-1:0]               r_p2, r_p3;
  logic [DATA_WIDTH-1:0]       c_p3, c_p4;

  assign stall    = vld_p4 & ~out_ready;
  assign en       = ~stall;
  assign in_ready = rst | ~stall;

  // Stage 1: full product P, or the raw add/sub/pass value
  assign diff_p0 = $signed({1'b0, in_a}) - $signed({1'b0, in_b});

  always_comb begin
    raw_p0 = '0;
    unique case (op_e'(in_op))
      OP_MUL:  raw_p0 = PW'(in_a) * PW'(in_b);
      OP_ADD:  raw_p0 = PW'(in_a) + PW'(in_b);
      OP_SUB:  raw_p0 = {{(PW-DATA_WIDTH-1){diff_p0[DATA_WIDTH]}}, diff_p0};
      OP_PASS: raw_p0 = PW'(in_a);
    endcase
  end

  dff_en #(.WIDTH(1)) u_vld_p1 (
    .clk(clk), .rst(rst), .en(en), .d(in_valid & in_ready), .q(vld_p1)
  );
  dff_en #(.WIDTH(2 + TAG_WIDTH + PW)) u_dat_p1 (
    .clk(clk), .rst(1'b0), .en(en),
    .d({in_op, in_tag, raw_p0}), .q({op_p1, tag_p1, raw_p1})
  );

  // Stage 2: Barrett quotient estimate t = floor(P*M / 2^k)
  assign t_p1 = TW'((XW'(raw_p1) * XW'(M)) >> PW);

  dff_en #(.WIDTH(1)) u_vld_p2 (
    .clk(clk), .rst(rst), .en(en), .d(vld_p1), .q(vld_p2)
  );
  dff_en #(.WIDTH(2 + TAG_WIDTH + RW + TW)) u_dat_p2 (
    .clk(clk), .rst(1'b0), .en(en),
    .d({op_p1, tag_p1, raw_p1[RW-1:0], t_p1}), .q({op_p2, tag_p2, raw_p2, t_p2})
  );

  // Stage 3: remainder r = P - t*Q (< 3Q, so RW bits of the difference are exact)
  always_comb begin
    r_p2 = raw_p2;
    if (op_e'(op_p2) == OP_MUL) r_p2 = raw_p2 - RW'(t_p2) * Q_R;
  end

  dff_en #(.WIDTH(1)) u_vld_p3 (
    .clk(clk), .rst(rst), .en(en), .d(vld_p2), .q(vld_p3)
  );
  dff_en #(.WIDTH(2 + TAG_WIDTH + RW)) u_dat_p3 (
    .clk(clk), .rst(1'b0), .en(en),
    .d({op_p2, tag_p2, r_p2}), .q({op_p3, tag_p3, r_p3})
  );

  // Stage 4: final conditional correction into [0, Q)
  always_comb begin
    c_p3 = '0;
    unique case (op_e'(op_p3))
      OP_MUL:  c_p3 = fold_barrett(r_p3);
      OP_ADD:  c_p3 = fold_add(r_p3);
      OP_SUB:  c_p3 = fold_sub($signed(r_p3));
      OP_PASS: c_p3 = r_p3[DATA_WIDTH-1:0];
    endcase
  end

  dff_en #(.WIDTH(1)) u_vld_p4 (
    .clk(clk), .rst(rst), .en(en), .d(vld_p3), .q(vld_p4)
  );
  dff_en #(.WIDTH(TAG_WIDTH + DATA_WIDTH)) u_dat_p4 (
    .clk(clk), .rst(rst), .en(en),
    .d({tag_p3, c_p3}), .q({tag_p4, c_p4})
  );

  assign out_valid = vld_p4;
  assign out_c     = c_p4;
  assign out_tag   = tag_p4;

endmodule

// File: tb/tb_mod_alu_pipe.sv
// Bench for mod_alu_pipe: directed vector table, stall/reset sequences,
// randomized traffic against a plain-arithmetic model, and a 23-bit instance.
module tb_mod_alu_pipe;
  import mod_alu_pipe_pkg::*;

  localparam longint QV = 3329;
  localparam longint Q23 = 8380417;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [11:0] in_a, in_b, out_c;
  logic [3:0]  in_tag, out_tag;

  logic        v23, r23, ov23;
  logic [1:0]  op23;
  logic [22:0] a23, b23, c23;
  logic [3:0]  tag23, otag23;

  mod_alu_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c), .out_tag(out_tag)
  );

  mod_alu_pipe #(.DATA_WIDTH(23), .Q(8380417), .TAG_WIDTH(4)) dut23 (
    .clk(clk), .rst(rst), .in_valid(v23), .in_ready(r23), .in_op(op23),
    .in_a(a23), .in_b(b23), .in_tag(tag23), .out_valid(ov23),
    .out_ready(1'b1), .out_c(c23), .out_tag(otag23)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint c; int tag; int t; bit strict; } exp_t;
  typedef struct { logic [1:0] op; logic [11:0] a; logic [11:0] b; logic [3:0] tag; longint exp; } vec_t;

  exp_t   q[$];
  vec_t   tbl[6];
  int     cyc, n_cmp, n_err, n_pop;
  bit     lat_strict, use_exp, last_acc, held, prev_rst, rand_ready;
  longint drv_exp, hold_c;
  int     hold_tag, stall_from, stall_len;

  function automatic longint ref_c(input logic [1:0] op, input longint a, input longint b, input longint m);
    case (op)
      2'b00:   return (a * b) % m;
      2'b01:   return (a + b) % m;
      2'b10:   return (a - b + m) % m;
      default: return a;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
      held = 1'b0;
      check("rst_in_ready", in_ready, 1);
      if (prev_rst) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_out_c", out_c, 0);
        check("rst_out_tag", out_tag, 0);
      end
    end else begin
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        q.push_back('{c: use_exp ? drv_exp : ref_c(in_op, in_a, in_b, QV),
                      tag: int'(in_tag), t: cyc, strict: lat_strict});
      end
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_c", out_c, hold_c);
        check("hold_tag", out_tag, hold_tag);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      else check("in_ready", in_ready, 1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          e = q.pop_front();
          n_pop++;
          check("out_c", out_c, e.c);
          check("out_tag", out_tag, e.tag);
          if (e.strict) check("latency", cyc - e.t, LATENCY);
        end
      end
      held     = out_valid && !out_ready;
      hold_c   = out_c;
      hold_tag = int'(out_tag);
    end
    prev_rst = rst;
  endtask

  task automatic tick();
    if (stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len) out_ready = 1'b0;
    else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [1:0] op, input logic [11:0] a, input logic [11:0] b,
                      input logic [3:0] tag, input longint exp, input bit use_e);
    int guard;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    use_exp = use_e; drv_exp = exp;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!last_acc && guard < 50);
    if (!last_acc) check("send_accept", last_acc, 1);
  endtask

  task automatic drain();
    int g;
    in_valid = 1'b0;
    g = 0;
    while (q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, g, p0;
    bit found;
    cyc = 0; n_cmp = 0; n_err = 0; n_pop = 0;
    lat_strict = 0; use_exp = 0; last_acc = 0; held = 0; prev_rst = 0; rand_ready = 0;
    drv_exp = 0; hold_c = 0; hold_tag = 0; stall_from = 0; stall_len = 0;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    v23 = 1'b0; op23 = 2'b00; a23 = '0; b23 = '0; tag23 = '0;

    tbl[0] = '{OP_MUL,  12'd1234, 12'd2345, 4'd3, 829};
    tbl[1] = '{OP_MUL,  12'd3328, 12'd3328, 4'd5, 1};
    tbl[2] = '{OP_MUL,  12'd0,    12'd3328, 4'd6, 0};
    tbl[3] = '{OP_ADD,  12'd3000, 12'd500,  4'd7, 171};
    tbl[4] = '{OP_SUB,  12'd5,    12'd10,   4'd8, 3324};
    tbl[5] = '{OP_PASS, 12'd77,   12'd1000, 4'd9, 77};

    @(posedge clk); #1;
    tick();
    tick();
    rst = 1'b0;

    // Back-to-back directed vectors, each 4 cycles after its transfer
    lat_strict = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 6; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].exp, 1'b1);
    drain();
    check("table_count", n_pop - p0, 6);
    use_exp = 1'b0;
    lat_strict = 1'b0;

    // 20 MULs with a 3-cycle downstream stall mid-stream
    p0 = n_pop;
    stall_from = cyc + 8;
    stall_len = 3;
    for (int i = 0; i < 20; i++)
      send(OP_MUL, 12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328)), 4'(i), 0, 1'b0);
    drain();
    stall_len = 0;
    check("stall_count", n_pop - p0, 20);

    // Reset with 3 samples in flight, then an input in the first cycle out of reset
    for (int i = 0; i < 3; i++) send(OP_ADD, 12'(i + 1), 12'(i + 2), 4'(12 + i), 0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_mid_valid", out_valid, 0);
    rst = 1'b0;
    lat_strict = 1'b1;
    send(OP_ADD, 12'd100, 12'd200, 4'd11, 0, 1'b0);
    in_valid = 1'b0;
    check("post_rst_valid", out_valid, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("post_rst_valid", out_valid, 0);
    end
    drain();
    lat_strict = 1'b0;

    // Randomized traffic with random valid and ready
    rand_ready = 1'b1;
    acc = 0;
    g = 0;
    in_valid = 1'b0;
    while (acc < 3000 && g < 20000) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 2'($urandom);
        in_a     = ($urandom_range(0, 7) == 0) ? 12'(QV - 1) : 12'($urandom_range(0, 3328));
        in_b     = ($urandom_range(0, 7) == 0) ? 12'(QV - 1) : 12'($urandom_range(0, 3328));
        in_tag   = 4'($urandom);
      end
      tick();
      if (last_acc) acc++;
      g++;
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    drain();
    check("rand_count", acc, 3000);

    // Wide-parameter instance: (Q-1)^2 mod Q = 1
    check("d23_in_ready", r23, 1);
    v23 = 1'b1; op23 = OP_MUL; a23 = 23'(Q23 - 1); b23 = 23'(Q23 - 1); tag23 = 4'd5;
    tick();
    v23 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (ov23) begin
        found = 1'b1;
        check("d23_out_c", c23, 1);
        check("d23_out_tag", otag23, 5);
        check("d23_latency", i + 1, LATENCY);
      end else begin
        tick();
      end
    end
    if (!found) check("d23_out_valid", ov23, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
